cpu_mem_arbiter: RTL and testbench
==================================

Name: cpu_mem_arbiter

Overview:
- Shares one memory port between the multi-cycle CPU's two channels: the instruction-fetch channel (PC request and instruction response) and the data channel (MemRead/MemWrite with address, data and strobe, plus read-data response).
- Sits between the custom CPU and the memory/UART interconnect in cpu_test_top.
- Keeps at most one transaction outstanding.
- Provides a wrapping counter of cycles in which an accepted-able request waits behind the other channel.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- RR_EN, 0, arbitration mode: 0 gives the data channel fixed priority; 1 selects round-robin.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- inst_req_valid  in  1  fetch request.
- inst_req_addr  in  ADDR_W  PC.
- inst_req_ready  out  1  fetch request accepted.
- inst_resp_valid  out  1  instruction valid.
- inst_resp_data  out  DATA_W  instruction.
- inst_resp_ready  in  1  CPU ready for instruction.
- data_read  in  1  load request.
- data_write  in  1  store request.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_wstrb  in  DATA_W/8  byte strobes.
- data_req_ack  out  1  data request accepted.
- data_resp_valid  out  1  load data valid.
- data_resp_data  out  DATA_W  load data.
- data_resp_ready  in  1  CPU ready for load data.
- mem_req_valid  out  1  memory request.
- mem_req_wen  out  1  1 = write.
- mem_req_addr  out  ADDR_W  memory address.
- mem_req_wdata  out  DATA_W  memory write data.
- mem_req_wstrb  out  DATA_W/8  memory byte strobes.
- mem_req_ready  in  1  memory accepts request.
- mem_resp_valid  in  1  memory read data valid.
- mem_resp_data  in  DATA_W  memory read data.
- mem_resp_ready  out  1  arbiter ready for read data.
- wait_cnt  out  32  wrapping count of cycles a request was blocked.

Behaviour:
- Reset: clk single clock domain. rst asynchronous active-high forces IDLE. All valid/ready/ack outputs go to 0; capture registers, last_grant and wait_cnt go to 0. A memory transaction in flight is abandoned; the memory side must be reset together with the arbiter.
- FSM states: IDLE, REQ, RESP.
- IDLE, pending requests:
  - inst pending = inst_req_valid.
  - data pending = data_read | data_write.
  - data_write takes precedence over data_read if both are set (protocol error; the request is treated as a write).
- IDLE, winner selection:
  - RR_EN=0: data wins.
  - RR_EN=1: on a tie, the channel not recorded in last_grant wins.
  - A single pending channel always wins.
- IDLE, grant:
  - Winner's inst_req_ready or data_req_ack is asserted combinationally in the same cycle.
  - Address, wdata, wstrb and wen are captured.
  - grant_sel and last_grant are recorded; state moves to REQ.
  - The loser sees ready/ack = 0.
- REQ:
  - mem_req_valid=1 and mem_req_* come from the capture registers, stable until mem_req_ready.
  - On handshake: write goes to IDLE; read goes to RESP.
  - Neither upstream ready/ack is asserted.
- RESP:
  - mem_resp_valid and mem_resp_data are routed to the granted channel's resp_valid/resp_data.
  - mem_resp_ready equals the granted channel's resp_ready.
  - The non-granted resp_valid is held at 0.
  - On handshake: go to IDLE.
- Latency:
  - Upstream acceptance occurs in cycle N; mem_req_valid is asserted from cycle N+1.
  - A back-to-back new grant is possible in the cycle after returning to IDLE.
  - Minimum read occupancy is 3 cycles with zero-wait memory; minimum write occupancy is 2 cycles.
- wait_cnt:
  - Increments by 1 in every cycle where a channel is pending but not granted, either because the other channel won in IDLE or because the arbiter is busy in REQ/RESP.
  - Counts at most 1 per cycle even if both channels wait.
  - Wraps from 0xFFFFFFFF to 0.
- Requester obligations: requests must hold valid and payload stable until ready/ack. The arbiter does not check this.
- Simultaneous mem_req_ready and mem_resp_valid in REQ: mem_resp_valid is ignored, and the response is taken in RESP from the next cycle onward.

Test Plan:
- Single fetch: inst_req_valid with addr 0x0000_0100, memory zero-wait returning 0x0000_0013 -> inst_req_ready at cycle 0; mem_req_valid with addr 0x100 and wen=0 at cycle 1; inst_resp_valid with data 0x13 at cycle 2; data_resp_valid stays 0.
- Store: data_write, addr 0x0C, wdata 0x0, wstrb 0xF -> data_req_ack at cycle 0; mem_req_wen=1, addr 0x0C, wstrb 0xF at cycle 1; back in IDLE at cycle 2; no response cycle.
- Tie with RR_EN=0: inst and data read both asserted -> data granted first. Inst granted only after the data response handshake. wait_cnt equals the number of inst blocked cycles (3 with zero-wait memory).
- Tie with RR_EN=1, both held continuously for 4 transactions -> grants alternate data, inst, data, inst (last_grant reset 0 = inst, so data goes first).
- Backpressure: mem_req_ready low for 5 cycles, then mem_resp_valid delayed; inst_resp_ready low 2 cycles -> mem_req_* stable for all 6 REQ cycles. Response is held and delivered on the third RESP cycle. No second grant occurs meanwhile.
- Reset mid-read: assert rst while in RESP -> all outputs 0 immediately (asynchronous), state IDLE, wait_cnt 0. After release, a fresh fetch completes normally.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between the CPU fetch channel and the load/store channel.
// At most one transaction is outstanding; wait_cnt counts cycles a request sat blocked.
module cpu_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR_EN  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req_valid,
  input  logic [ADDR_W-1:0]   inst_req_addr,
  output logic                inst_req_ready,
  output logic                inst_resp_valid,
  output logic [DATA_W-1:0]   inst_resp_data,
  input  logic                inst_resp_ready,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic                data_req_ack,
  output logic                data_resp_valid,
  output logic [DATA_W-1:0]   data_resp_data,
  input  logic                data_resp_ready,
  output logic                mem_req_valid,
  output logic                mem_req_wen,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_req_ready,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                mem_resp_ready,
  output logic [31:0]         wait_cnt
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state_q, state_d;
  logic                grant_sel_q, grant_sel_d;    // 1 = data channel owns the port
  logic                last_grant_q, last_grant_d;  // 1 = data channel was granted last
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [31:0]         wait_cnt_q, wait_cnt_d;

  logic inst_pend, data_pend, data_win, is_idle, blocked, resp_ready_sel;

  always_comb begin
    inst_pend = inst_req_valid;
    data_pend = data_read | data_write;
    is_idle   = (state_q == IDLE);

    // On a tie, fixed mode favours data; round-robin favours whoever was not granted last.
    if (inst_pend && data_pend) begin
      data_win = (RR_EN == 0) ? 1'b1 : ~last_grant_q;
    end else begin
      data_win = data_pend;
    end

    // Busy cycles block any request; in IDLE only the losing side of a tie is blocked.
    blocked = is_idle ? (inst_pend & data_pend) : (inst_pend | data_pend);
    wait_cnt_d = blocked ? wait_cnt_q + 32'd1 : wait_cnt_q;

    resp_ready_sel = grant_sel_q ? data_resp_ready : inst_resp_ready;

    state_d      = state_q;
    grant_sel_d  = grant_sel_q;
    last_grant_d = last_grant_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;

    case (state_q)
      IDLE: begin
        if (inst_pend || data_pend) begin
          state_d      = REQ;
          grant_sel_d  = data_win;
          last_grant_d = data_win;
          if (data_win) begin
            addr_d  = data_addr;
            wdata_d = data_wdata;
            wstrb_d = data_wstrb;
            wen_d   = data_write;
          end else begin
            addr_d  = inst_req_addr;
            wdata_d = '0;
            wstrb_d = '0;
            wen_d   = 1'b0;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = wen_q ? IDLE : RESP;
        end
      end
      RESP: begin
        if (mem_resp_valid && resp_ready_sel) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_sel_q  <= 1'b0;
      last_grant_q <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_sel_q  <= grant_sel_d;
      last_grant_q <= last_grant_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Grants are combinational so a requester is accepted in the cycle it asks.
  assign inst_req_ready  = ~rst & is_idle & inst_pend & ~data_win;
  assign data_req_ack    = ~rst & is_idle & data_pend & data_win;

  assign mem_req_valid   = (state_q == REQ);
  assign mem_req_wen     = wen_q;
  assign mem_req_addr    = addr_q;
  assign mem_req_wdata   = wdata_q;
  assign mem_req_wstrb   = wstrb_q;

  assign mem_resp_ready  = (state_q == RESP) & resp_ready_sel;
  assign inst_resp_valid = (state_q == RESP) & ~grant_sel_q & mem_resp_valid;
  assign data_resp_valid = (state_q == RESP) &  grant_sel_q & mem_resp_valid;
  assign inst_resp_data  = mem_resp_data;
  assign data_resp_data  = mem_resp_data;

  assign wait_cnt        = wait_cnt_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: a fixed-priority instance and a round-robin
// instance share upstream stimulus, each with its own simple memory model.
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req_valid;
  logic [31:0] inst_req_addr;
  logic        inst_resp_ready;
  logic        data_read, data_write;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_resp_ready;
  logic        mem_req_ready;
  logic        resp_en;

  logic        inst_req_ready_a, inst_resp_valid_a, data_req_ack_a, data_resp_valid_a;
  logic [31:0] inst_resp_data_a, data_resp_data_a;
  logic        mem_req_valid_a, mem_req_wen_a, mem_resp_valid_a, mem_resp_ready_a;
  logic [31:0] mem_req_addr_a, mem_req_wdata_a, mem_resp_data_a, wait_cnt_a;
  logic [3:0]  mem_req_wstrb_a;
  logic        pend_a;

  logic        inst_req_ready_b, inst_resp_valid_b, data_req_ack_b, data_resp_valid_b;
  logic [31:0] inst_resp_data_b, data_resp_data_b;
  logic        mem_req_valid_b, mem_req_wen_b, mem_resp_valid_b, mem_resp_ready_b;
  logic [31:0] mem_req_addr_b, mem_req_wdata_b, mem_resp_data_b, wait_cnt_b;
  logic [3:0]  mem_req_wstrb_b;
  logic        pend_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0)) u_fix (
    .clk(clk), .rst(rst),
    .inst_req_valid(inst_req_valid), .inst_req_addr(inst_req_addr), .inst_req_ready(inst_req_ready_a),
    .inst_resp_valid(inst_resp_valid_a), .inst_resp_data(inst_resp_data_a), .inst_resp_ready(inst_resp_ready),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_req_ack(data_req_ack_a), .data_resp_valid(data_resp_valid_a),
    .data_resp_data(data_resp_data_a), .data_resp_ready(data_resp_ready),
    .mem_req_valid(mem_req_valid_a), .mem_req_wen(mem_req_wen_a), .mem_req_addr(mem_req_addr_a),
    .mem_req_wdata(mem_req_wdata_a), .mem_req_wstrb(mem_req_wstrb_a), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid_a), .mem_resp_data(mem_resp_data_a), .mem_resp_ready(mem_resp_ready_a),
    .wait_cnt(wait_cnt_a)
  );

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1)) u_rr (
    .clk(clk), .rst(rst),
    .inst_req_valid(inst_req_valid), .inst_req_addr(inst_req_addr), .inst_req_ready(inst_req_ready_b),
    .inst_resp_valid(inst_resp_valid_b), .inst_resp_data(inst_resp_data_b), .inst_resp_ready(inst_resp_ready),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_req_ack(data_req_ack_b), .data_resp_valid(data_resp_valid_b),
    .data_resp_data(data_resp_data_b), .data_resp_ready(data_resp_ready),
    .mem_req_valid(mem_req_valid_b), .mem_req_wen(mem_req_wen_b), .mem_req_addr(mem_req_addr_b),
    .mem_req_wdata(mem_req_wdata_b), .mem_req_wstrb(mem_req_wstrb_b), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid_b), .mem_resp_data(mem_resp_data_b), .mem_resp_ready(mem_resp_ready_b),
    .wait_cnt(wait_cnt_b)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : ~a;
  endfunction

  // Memory models: a read request is answered from the following cycle while resp_en is high.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_a <= 1'b0;
      mem_resp_data_a <= '0;
    end else if (mem_req_valid_a && mem_req_ready && !mem_req_wen_a) begin
      pend_a <= 1'b1;
      mem_resp_data_a <= mem_fn(mem_req_addr_a);
    end else if (mem_resp_valid_a && mem_resp_ready_a) begin
      pend_a <= 1'b0;
    end
  end
  assign mem_resp_valid_a = pend_a & resp_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_b <= 1'b0;
      mem_resp_data_b <= '0;
    end else if (mem_req_valid_b && mem_req_ready && !mem_req_wen_b) begin
      pend_b <= 1'b1;
      mem_resp_data_b <= mem_fn(mem_req_addr_b);
    end else if (mem_resp_valid_b && mem_resp_ready_b) begin
      pend_b <= 1'b0;
    end
  end
  assign mem_resp_valid_b = pend_b & resp_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance to 1 time unit after the next rising edge; inputs change here, checks follow #1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    inst_req_valid = 0; inst_req_addr = '0; inst_resp_ready = 1;
    data_read = 0; data_write = 0; data_addr = '0; data_wdata = '0; data_wstrb = '0;
    data_resp_ready = 1; mem_req_ready = 1; resp_en = 1;
    step();
    #1;
    chk("rst_mem_req_valid", mem_req_valid_a, 0);
    chk("rst_wait_cnt", wait_cnt_a, 0);
    chk("rst_inst_resp_valid", inst_resp_valid_a, 0);
    step();
    rst = 1'b0;

    // Single fetch
    step();
    inst_req_valid = 1; inst_req_addr = 32'h100;
    #1 chk("fetch_ready_c0", inst_req_ready_a, 1);
    chk("fetch_dack_c0", data_req_ack_a, 0);
    step();
    inst_req_valid = 0;
    #1 chk("fetch_mreq_c1", mem_req_valid_a, 1);
    chk("fetch_addr_c1", mem_req_addr_a, 32'h100);
    chk("fetch_wen_c1", mem_req_wen_a, 0);
    step();
    #1 chk("fetch_rvalid_c2", inst_resp_valid_a, 1);
    chk("fetch_rdata_c2", inst_resp_data_a, 32'h13);
    chk("fetch_dvalid_c2", data_resp_valid_a, 0);
    step();
    #1 chk("fetch_idle_c3", mem_req_valid_a, 0);

    // Store
    data_write = 1; data_addr = 32'h0C; data_wdata = 32'h0; data_wstrb = 4'hF;
    #1 chk("st_ack_c0", data_req_ack_a, 1);
    step();
    data_write = 0;
    #1 chk("st_wen_c1", mem_req_wen_a, 1);
    chk("st_addr_c1", mem_req_addr_a, 32'h0C);
    chk("st_wstrb_c1", {28'h0, mem_req_wstrb_a}, 32'hF);
    step();
    #1 chk("st_idle_c2", mem_req_valid_a, 0);
    chk("st_no_resp_c2", mem_resp_ready_a, 0);
    chk("st_wait_cnt", wait_cnt_a, 0);

    // Tie, fixed priority: data first, inst waits 3 cycles
    step();
    inst_req_valid = 1; inst_req_addr = 32'h200;
    data_read = 1; data_addr = 32'h40;
    #1 chk("tie_dack_c0", data_req_ack_a, 1);
    chk("tie_iready_c0", inst_req_ready_a, 0);
    step();
    data_read = 0;
    #1 chk("tie_addr_c1", mem_req_addr_a, 32'h40);
    chk("tie_iready_c1", inst_req_ready_a, 0);
    step();
    #1 chk("tie_dvalid_c2", data_resp_valid_a, 1);
    chk("tie_ddata_c2", data_resp_data_a, 32'hFFFF_FFBF);
    chk("tie_ivalid_c2", inst_resp_valid_a, 0);
    step();
    #1 chk("tie_iready_c3", inst_req_ready_a, 1);
    chk("tie_wait_cnt", wait_cnt_a, 3);
    step();
    inst_req_valid = 0;
    #1 chk("tie_iaddr_c4", mem_req_addr_a, 32'h200);
    step();
    #1 chk("tie_idata_c5", inst_resp_data_a, 32'hFFFF_FDFF);
    chk("tie_ivalid_c5", inst_resp_valid_a, 1);
    step();

    // Backpressure on both memory request and response
    mem_req_ready = 0; resp_en = 0; inst_resp_ready = 0;
    inst_req_valid = 1; inst_req_addr = 32'h300;
    #1 chk("bp_iready_c0", inst_req_ready_a, 1);
    for (int k = 1; k <= 6; k++) begin
      step();
      inst_req_valid = 0;
      data_read = 1; data_addr = 32'h80;
      mem_req_ready = (k == 6);
      #1 chk($sformatf("bp_valid_%0d", k), mem_req_valid_a, 1);
      chk($sformatf("bp_addr_%0d", k), mem_req_addr_a, 32'h300);
      chk($sformatf("bp_dack_%0d", k), data_req_ack_a, 0);
    end
    step();
    #1 chk("bp_r1_ivalid", inst_resp_valid_a, 0);
    chk("bp_r1_mreq", mem_req_valid_a, 0);
    step();
    resp_en = 1;
    #1 chk("bp_r2_ivalid", inst_resp_valid_a, 1);
    chk("bp_r2_mrready", mem_resp_ready_a, 0);
    chk("bp_r2_dack", data_req_ack_a, 0);
    step();
    inst_resp_ready = 1;
    #1 chk("bp_r3_ivalid", inst_resp_valid_a, 1);
    chk("bp_r3_idata", inst_resp_data_a, 32'hFFFF_FCFF);
    chk("bp_r3_mrready", mem_resp_ready_a, 1);
    step();
    #1 chk("bp_r4_dack", data_req_ack_a, 1);
    chk("bp_wait_cnt", wait_cnt_a, 12);
    step();
    data_read = 0;
    step();
    step();

    // Reset while a read is waiting in RESP
    resp_en = 0;
    inst_req_valid = 1; inst_req_addr = 32'h100;
    step();
    inst_req_valid = 0;
    step();
    #1 chk("rr_pre_mrready", mem_resp_ready_a, 1);
    rst = 1'b1;
    #1 chk("rmid_mrready", mem_resp_ready_a, 0);
    chk("rmid_wait_cnt", wait_cnt_a, 0);
    chk("rmid_mreq", mem_req_valid_a, 0);
    chk("rmid_ivalid", inst_resp_valid_a, 0);
    step();
    rst = 1'b0; resp_en = 1;
    step();
    inst_req_valid = 1; inst_req_addr = 32'h100;
    #1 chk("rpost_iready", inst_req_ready_a, 1);
    step();
    inst_req_valid = 0;
    #1 chk("rpost_addr", mem_req_addr_a, 32'h100);
    step();
    #1 chk("rpost_idata", inst_resp_data_a, 32'h13);
    chk("rpost_ivalid", inst_resp_valid_a, 1);
    step();

    // Round-robin with both channels held: data, inst, data, inst
    do_reset();
    inst_req_valid = 1; inst_req_addr = 32'h400;
    data_read = 1; data_addr = 32'h500;
    for (int g = 0; g < 4; g++) begin
      #1 chk($sformatf("rr_dack_%0d", g), data_req_ack_b, (g % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_iready_%0d", g), inst_req_ready_b, (g % 2 == 1) ? 1 : 0);
      step();
      chk($sformatf("rr_addr_%0d", g), mem_req_addr_b, (g % 2 == 0) ? 32'h500 : 32'h400);
      step();
      step();
    end
    chk("rr_wait_cnt", wait_cnt_b, 12);
    inst_req_valid = 0; data_read = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
